// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multiport register file.
// Include this file before the modules that import it.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    localparam int RF_DATA_W   = 64;
    localparam int RF_NUM_REGS = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by a reserve, cleared by a
// completing write or by the bulk-clear sweep; NUM_RD combinational lookups.
module regfile_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 31,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           set_en,
    input  logic [ADDR_W-1:0]              set_idx,
    input  logic                           clr_en,
    input  logic [ADDR_W-1:0]              clr_idx,
    input  logic                           wipe_en,
    input  logic [ADDR_W-1:0]              wipe_idx,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  lookup_idx,
    output logic [NUM_RD-1:0]              lookup_pending
);

    localparam logic [ADDR_W:0] IDX_LIMIT = (ADDR_W+1)'(NUM_REGS);

    logic [NUM_REGS-1:0] pending;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            if (gi == ZERO_REG) begin : g_zero
                assign pending[gi] = 1'b0;
            end else begin : g_live
                logic pend_reg;
                // A reserve outranks a same-cycle write: the newer producer is still in flight.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        pend_reg <= 1'b0;
                    end else if (set_en && set_idx == IDX) begin
                        pend_reg <= 1'b1;
                    end else if ((clr_en && clr_idx == IDX) || (wipe_en && wipe_idx == IDX)) begin
                        pend_reg <= 1'b0;
                    end
                end
                assign pending[gi] = pend_reg;
            end
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_lookup
            assign lookup_pending[gi] = ({1'b0, lookup_idx[gi]} < IDX_LIMIT)
                                      ? pending[lookup_idx[gi]] : 1'b0;
        end
    endgenerate

endmodule

// File: rtl/regfile_multiport_sb.sv
// CPU register file with NUM_RD combinational read ports, one write port, zero
// register, same-cycle write bypass, pending-write scoreboard and bulk-clear engine.
module regfile_multiport_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           RegWrite,
    input  logic [ADDR_W-1:0]              WriteRegister,
    input  logic [DATA_W-1:0]              WriteData,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  ReadRegister,
    output logic [NUM_RD-1:0][DATA_W-1:0]  ReadData,
    output logic [NUM_RD-1:0]              ReadPending,
    input  logic                           Reserve,
    input  logic [ADDR_W-1:0]              ReserveRegister,
    input  logic                           Clear,
    output logic                           Busy,
    output logic                           Done
);

    localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W:0]   IDX_LIMIT = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0]   LAST_IDX  = (ADDR_W+1)'(NUM_REGS - 1);

    rf_state_t             state_reg;
    logic [ADDR_W:0]       count_reg;
    logic                  done_reg;
    logic                  idle;
    logic                  write_ok;
    logic                  wipe_en;
    logic [ADDR_W-1:0]     wipe_idx;
    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic [NUM_RD-1:0]     sb_pending;

    function automatic logic idx_valid(input logic [ADDR_W-1:0] idx);
        return (idx != ZERO_IDX) && ({1'b0, idx} < IDX_LIMIT);
    endfunction

    assign idle     = (state_reg == RF_IDLE);
    assign write_ok = RegWrite && idle && idx_valid(WriteRegister);
    assign wipe_en  = (state_reg == RF_CLEAR);
    assign wipe_idx = count_reg[ADDR_W-1:0];
    assign Busy     = wipe_en;
    assign Done     = done_reg;

    // Bulk-clear sequencer: one register per cycle, Done pulses after the last index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= RF_IDLE;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                RF_IDLE: begin
                    if (Clear) begin
                        state_reg <= RF_CLEAR;
                        count_reg <= '0;
                    end
                end
                RF_CLEAR: begin
                    count_reg <= count_reg + (ADDR_W+1)'(1);
                    if (count_reg == LAST_IDX) begin
                        state_reg <= RF_IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= RF_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            logic [DATA_W-1:0] data_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_reg <= '0;
                end else if (write_ok && WriteRegister == IDX) begin
                    data_reg <= WriteData;
                end else if (wipe_en && wipe_idx == IDX) begin
                    data_reg <= '0;
                end
            end
            assign regs[gi] = data_reg;
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic hit;
            // write_ok already excludes the zero register, out-of-range indices and CLEAR.
            assign hit = (BYPASS != 0) && write_ok && (WriteRegister == ReadRegister[gi]);
            assign ReadData[gi] = !idx_valid(ReadRegister[gi]) ? {DATA_W{1'b0}}
                                : hit ? WriteData
                                : regs[ReadRegister[gi]];
            assign ReadPending[gi] = hit ? 1'b0 : sb_pending[gi];
        end
    endgenerate

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk            (clk),
        .reset          (reset),
        .set_en         (Reserve && idle),
        .set_idx        (ReserveRegister),
        .clr_en         (write_ok),
        .clr_idx        (WriteRegister),
        .wipe_en        (wipe_en),
        .wipe_idx       (wipe_idx),
        .lookup_idx     (ReadRegister),
        .lookup_pending (sb_pending)
    );

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Directed bench for regfile_multiport_sb: a BYPASS=1 and a BYPASS=0 instance share
// stimulus; expectations are queued when driven and popped once outputs settle.
module tb_regfile_multiport_sb;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    RegWrite = 1'b0;
    logic [AW-1:0]           WriteRegister = '0;
    logic [DW-1:0]           WriteData = '0;
    logic [NR-1:0][AW-1:0]   ReadRegister = '0;
    logic                    Reserve = 1'b0;
    logic [AW-1:0]           ReserveRegister = '0;
    logic                    Clear = 1'b0;
    logic [NR-1:0][DW-1:0]   rd_data, nb_data;
    logic [NR-1:0]           rd_pend, nb_pend;
    logic                    busy, done, nb_busy, nb_done;

    always #5 clk = ~clk;

    regfile_multiport_sb #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister(ReadRegister), .ReadData(rd_data),
        .ReadPending(rd_pend), .Reserve(Reserve), .ReserveRegister(ReserveRegister),
        .Clear(Clear), .Busy(busy), .Done(done)
    );

    regfile_multiport_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister(ReadRegister), .ReadData(nb_data),
        .ReadPending(nb_pend), .Reserve(Reserve), .ReserveRegister(ReserveRegister),
        .Clear(Clear), .Busy(nb_busy), .Done(nb_done)
    );

    // kind: 0 data, 1 pending, 2 busy, 3 done, 4 nb data, 5 nb pending, 6 nb busy
    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [63:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [63:0] model [32];

    function automatic logic [63:0] observe(input int kind, input int port);
        case (kind)
            0:       return rd_data[port];
            1:       return 64'(rd_pend[port]);
            2:       return 64'(busy);
            3:       return 64'(done);
            4:       return nb_data[port];
            5:       return 64'(nb_pend[port]);
            6:       return 64'(nb_busy);
            default: return 'x;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int kind, input int port, input logic [63:0] val);
        exp_t e;
        e.tag = tag; e.kind = kind; e.port = port; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [63:0] obs;
        #1;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.kind, e.port);
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic compare_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic step(input string name);
        $display("[%0t] step: %s", $time, name);
    endtask

    initial begin
        int busy_cnt, done_cnt, done_at, nb_done_cnt, busy_seen, done_seen;

        // ---- 1: reset state ----
        step("reset, read all indices");
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister[0] = AW'(i);
            ReadRegister[1] = AW'(31 - i);
            expect_out("rst_data0", 0, 0, 64'd0);
            expect_out("rst_data1", 0, 1, 64'd0);
            expect_out("rst_pend0", 1, 0, 64'd0);
            expect_out("rst_pend1", 1, 1, 64'd0);
            expect_out("rst_nb_data0", 4, 0, 64'd0);
            check_all();
        end
        expect_out("rst_busy", 2, 0, 64'd0);
        expect_out("rst_done", 3, 0, 64'd0);
        expect_out("rst_nb_busy", 6, 0, 64'd0);
        check_all();

        // ---- 2: bypass ----
        step("write r5 with same-cycle read");
        tick();
        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'h1234;
        ReadRegister[0] = 5'd5; ReadRegister[1] = 5'd5;
        expect_out("byp_data", 0, 0, 64'h1234);
        expect_out("byp_pend", 1, 0, 64'd0);
        expect_out("nobyp_data", 4, 0, 64'd0);
        check_all();
        tick();
        RegWrite = 1'b0;
        expect_out("r5_stored", 0, 1, 64'h1234);
        expect_out("nb_r5_stored", 4, 1, 64'h1234);
        check_all();

        // ---- 3: zero register ----
        step("write and reserve r31");
        tick();
        RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'hFFFF;
        ReadRegister[0] = 5'd31;
        expect_out("r31_byp", 0, 0, 64'd0);
        check_all();
        tick();
        RegWrite = 1'b0;
        expect_out("r31_read", 0, 0, 64'd0);
        check_all();
        Reserve = 1'b1; ReserveRegister = 5'd31;
        tick();
        Reserve = 1'b0;
        expect_out("r31_pend", 1, 0, 64'd0);
        check_all();

        // ---- 4: scoreboard ----
        step("reserve/write r3");
        Reserve = 1'b1; ReserveRegister = 5'd3;
        ReadRegister[0] = 5'd3; ReadRegister[1] = 5'd4;
        expect_out("r3_pend_before", 1, 0, 64'd0);
        check_all();
        tick();
        Reserve = 1'b0;
        expect_out("r3_pend_set", 1, 0, 64'd1);
        expect_out("r4_pend_clear", 1, 1, 64'd0);
        check_all();
        tick();
        RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'hABCD;
        expect_out("r3_wr_byp_pend", 1, 0, 64'd0);
        expect_out("r3_wr_byp_data", 0, 0, 64'hABCD);
        expect_out("nb_r3_wr_pend", 5, 0, 64'd1);
        check_all();
        tick();
        RegWrite = 1'b0;
        expect_out("r3_pend_after_wr", 1, 0, 64'd0);
        expect_out("nb_r3_pend_after_wr", 5, 0, 64'd0);
        expect_out("r3_data", 0, 0, 64'hABCD);
        check_all();
        tick();
        Reserve = 1'b1; ReserveRegister = 5'd3;
        RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'h55;
        expect_out("r3_both_byp", 0, 0, 64'h55);
        expect_out("r3_both_byp_pend", 1, 0, 64'd0);
        check_all();
        tick();
        Reserve = 1'b0; RegWrite = 1'b0;
        expect_out("r3_both_pend", 1, 0, 64'd1);
        expect_out("nb_r3_both_pend", 5, 0, 64'd1);
        expect_out("r3_both_data", 0, 0, 64'h55);
        check_all();

        // ---- 5: bulk clear ----
        step("fill r0..r30");
        for (int i = 0; i < 31; i++) begin
            model[i] = {32'hA5A5_0000 + 32'(i), 32'(i * 3 + 1)};
            RegWrite = 1'b1; WriteRegister = AW'(i); WriteData = model[i];
            tick();
        end
        RegWrite = 1'b0;
        for (int i = 0; i < 31; i++) begin
            ReadRegister[0] = AW'(i);
            expect_out("fill_read", 0, 0, model[i]);
            check_all();
        end

        step("clear with same-cycle reserve r9 and write r30");
        model[30] = 64'h3030_3030_3030_3030;
        Clear = 1'b1; Reserve = 1'b1; ReserveRegister = 5'd9;
        RegWrite = 1'b1; WriteRegister = 5'd30; WriteData = model[30];
        ReadRegister[0] = 5'd0;
        expect_out("clr_busy_pre", 2, 0, 64'd0);
        check_all();
        busy_cnt = 0; done_cnt = 0; done_at = 0; nb_done_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 1) begin
                Clear = 1'b0; Reserve = 1'b0; RegWrite = 1'b0;
            end
            if (n == 2) begin
                ReadRegister[0] = 5'd30; ReadRegister[1] = 5'd9;
                expect_out("clr_r30_written", 0, 0, model[30]);
                expect_out("clr_r9_reserved", 1, 1, 64'd1);
            end
            if (n == 3) begin
                RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'hDEAD;
                Reserve = 1'b1; ReserveRegister = 5'd8; Clear = 1'b1;
                ReadRegister[0] = 5'd7; ReadRegister[1] = 5'd0;
                expect_out("busy_no_bypass", 0, 0, model[7]);
                expect_out("busy_r0_wiped", 0, 1, 64'd0);
            end
            if (n == 4) begin
                RegWrite = 1'b0; Reserve = 1'b0; Clear = 1'b0;
                ReadRegister[0] = 5'd7; ReadRegister[1] = 5'd8;
                expect_out("busy_write_dropped", 0, 0, model[7]);
                expect_out("busy_reserve_dropped", 1, 1, 64'd0);
            end
            check_all();
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (nb_done) nb_done_cnt++;
        end
        compare_int("clr_busy_cycles", busy_cnt, 32);
        compare_int("clr_done_pulses", done_cnt, 1);
        compare_int("clr_done_cycle", done_at, 33);
        compare_int("nb_clr_done_pulses", nb_done_cnt, 1);
        for (int i = 0; i < 32; i++) begin
            ReadRegister[0] = AW'(i);
            ReadRegister[1] = AW'(i);
            expect_out("post_clr_data", 0, 0, 64'd0);
            expect_out("post_clr_pend", 1, 1, 64'd0);
            expect_out("nb_post_clr_data", 4, 0, 64'd0);
            check_all();
        end

        // ---- 6: reset mid-clear ----
        step("async reset at clear cycle 10");
        tick();
        RegWrite = 1'b1; WriteRegister = 5'd20; WriteData = 64'h2020;
        tick();
        RegWrite = 1'b0; Reserve = 1'b1; ReserveRegister = 5'd25;
        tick();
        Reserve = 1'b0; Clear = 1'b1;
        ReadRegister[0] = 5'd20; ReadRegister[1] = 5'd25;
        for (int n = 1; n <= 10; n++) begin
            tick();
            Clear = 1'b0;
        end
        expect_out("pre_rst_r20", 0, 0, 64'h2020);
        expect_out("pre_rst_r25_pend", 1, 1, 64'd1);
        expect_out("pre_rst_busy", 2, 0, 64'd1);
        check_all();
        reset = 1'b1;
        expect_out("mid_rst_r20", 0, 0, 64'd0);
        expect_out("mid_rst_pend", 1, 1, 64'd0);
        expect_out("mid_rst_busy", 2, 0, 64'd0);
        expect_out("mid_rst_done", 3, 0, 64'd0);
        check_all();
        busy_seen = 0; done_seen = 0;
        for (int n = 0; n < 7; n++) begin
            tick();
            if (n == 1) reset = 1'b0;
            #1;
            if (busy) busy_seen++;
            if (done) done_seen++;
        end
        compare_int("abort_busy_seen", busy_seen, 0);
        compare_int("abort_done_seen", done_seen, 0);

        step("clear restarts from index 0");
        RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 64'h77;
        tick();
        WriteRegister = 5'd1; WriteData = 64'h88;
        tick();
        RegWrite = 1'b0; Clear = 1'b1;
        ReadRegister[0] = 5'd0; ReadRegister[1] = 5'd1;
        tick();
        Clear = 1'b0;
        tick();
        expect_out("restart_r0", 0, 0, 64'd0);
        expect_out("restart_r1", 0, 1, 64'h88);
        expect_out("restart_busy", 2, 0, 64'd1);
        check_all();
        done_cnt = 0;
        for (int n = 0; n < 40 && (busy || done); n++) begin
            tick();
            #1;
            if (done) done_cnt++;
        end
        compare_int("restart_done_pulses", done_cnt, 1);
        expect_out("restart_idle", 2, 0, 64'd0);
        expect_out("restart_r1_wiped", 0, 1, 64'd0);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
